// File: rtl/engine_csr_index_chunk_configure_engine_pkg.sv
// Shared types for the CSR index chunk configure engine: packet modes, FSM states, config bundle.
package engine_csr_index_chunk_configure_engine_pkg;

    localparam int PKG_INDEX_W = 32;
    localparam int PKG_META_W  = 64;

    typedef enum logic [1:0] {
        MODE_OFFSET_LEN = 2'd0,
        MODE_START_END  = 2'd1
    } csr_index_chunk_mode_e;

    typedef logic [1:0] csr_index_chunk_state_t;

    localparam csr_index_chunk_state_t S_IDLE = 2'd0;
    localparam csr_index_chunk_state_t S_CALC = 2'd1;
    localparam csr_index_chunk_state_t S_EMIT = 2'd2;

    typedef struct packed {
        logic [PKG_INDEX_W-1:0] index_start;
        logic [PKG_INDEX_W-1:0] index_end;
        logic [PKG_INDEX_W-1:0] array_size;
        logic [PKG_META_W-1:0]  meta;
        logic                   last;
    } csr_index_chunk_cfg_t;

    // A max_chunk of zero means "no splitting": the whole remainder goes out at once.
    function automatic logic [PKG_INDEX_W-1:0] chunk_of(input logic [PKG_INDEX_W-1:0] remaining,
                                                        input logic [PKG_INDEX_W-1:0] max_chunk);
        if ((max_chunk == '0) || (remaining < max_chunk)) begin
            return remaining;
        end
        return max_chunk;
    endfunction

endpackage

// File: rtl/engine_csr_index_chunk_fifo.sv
// Synchronous first-word-fall-through FIFO; head_dat is valid whenever empty is low.
// Pushes when full and pops when empty are ignored; active-low synchronous reset empties it.
module engine_csr_index_chunk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/engine_csr_index_chunk_configure_engine.sv
// Filters setup packets by buffer ID and splits each range into <=MAX_CHUNK index configs (stats: ENGINE_CSR_INDEX_CHUNK_STATS_EN).
// Latency: first config valid 3 edges after the accepting edge; then one chunk per cycle.
// Backpressure: cfg_* held while cfg_ready low; in_ready drops when the input FIFO is full.
module engine_csr_index_chunk_configure_engine
    import engine_csr_index_chunk_configure_engine_pkg::*;
#(
    parameter int INDEX_W    = PKG_INDEX_W,
    parameter int META_W     = PKG_META_W,
    parameter int BUF_ID_W   = 4,
    parameter int SETUP_ID_A = 1,
    parameter int SETUP_ID_B = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_CHUNK  = 256,
    parameter int STRIDE     = 1
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUF_ID_W-1:0] in_buffer,
    input  logic [1:0]          in_mode,
    input  logic [INDEX_W-1:0]  in_field0,
    input  logic [INDEX_W-1:0]  in_field1,
    input  logic [META_W-1:0]   in_meta,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [INDEX_W-1:0]  cfg_index_start,
    output logic [INDEX_W-1:0]  cfg_index_end,
    output logic [INDEX_W-1:0]  cfg_array_size,
    output logic [INDEX_W-1:0]  cfg_stride,
    output logic [META_W-1:0]   cfg_meta,
    output logic                cfg_last,
    output logic [1:0]          err,
    output logic                fifo_setup_signal
`ifdef ENGINE_CSR_INDEX_CHUNK_STATS_EN
    ,
    output logic [31:0]         stat_cfg_count,
    output logic [31:0]         stat_drop_count
`endif
);

    localparam int ENTRY_W = 2 + 2*INDEX_W + META_W;

    logic                   setup_q, setup_d;
    csr_index_chunk_state_t state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [INDEX_W-1:0]     f0_q, f0_d;
    logic [INDEX_W-1:0]     f1_q, f1_d;
    logic [META_W-1:0]      meta_q, meta_d;
    logic [INDEX_W-1:0]     start_q, start_d;
    logic [INDEX_W-1:0]     remaining_q, remaining_d;
    csr_index_chunk_cfg_t   cfg_q, cfg_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic [1:0]             err_q, err_d;

    logic                   id_match;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_head;
    logic [1:0]             head_mode;
    logic [INDEX_W-1:0]     head_f0;
    logic [INDEX_W-1:0]     head_f1;
    logic [META_W-1:0]      head_meta;

    logic [INDEX_W-1:0]     calc_size;
    logic                   calc_drop;
    logic [INDEX_W-1:0]     emit_start;
    logic [INDEX_W-1:0]     emit_rem;
    logic [INDEX_W-1:0]     emit_chunk;

    assign id_match  = (in_buffer == BUF_ID_W'(SETUP_ID_A)) || (in_buffer == BUF_ID_W'(SETUP_ID_B));
    assign in_ready  = ~fifo_full & ~setup_q;
    assign fifo_push = in_valid & in_ready & id_match;
    assign {head_mode, head_f0, head_f1, head_meta} = fifo_head;

    engine_csr_index_chunk_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .push     (fifo_push),
        .push_dat ({in_mode, in_field0, in_field1, in_meta}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // On a handshake the next chunk is built from the post-advance start/remainder so
    // back-to-back chunks leave one per cycle.
    assign emit_start = cfg_valid_q ? (start_q + cfg_q.array_size) : start_q;
    assign emit_rem   = cfg_valid_q ? (remaining_q - cfg_q.array_size) : remaining_q;
    assign emit_chunk = chunk_of(emit_rem, INDEX_W'(MAX_CHUNK));

    always_comb begin
        setup_d     = 1'b0;
        state_d     = state_q;
        mode_d      = mode_q;
        f0_d        = f0_q;
        f1_d        = f1_q;
        meta_d      = meta_q;
        start_d     = start_q;
        remaining_d = remaining_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        err_d       = err_q;
        fifo_pop    = 1'b0;
        calc_size   = '0;
        calc_drop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mode_d   = head_mode;
                    f0_d     = head_f0;
                    f1_d     = head_f1;
                    meta_d   = head_meta;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                case (mode_q)
                    MODE_OFFSET_LEN: begin
                        // f0+f1 exceeds the index space exactly when f1 > (all-ones - f0)
                        if (f1_q > ~f0_q) begin
                            calc_size = ~f0_q;
                            err_d[0]  = 1'b1;
                        end else begin
                            calc_size = f1_q;
                        end
                    end
                    MODE_START_END: begin
                        calc_size = (f1_q > f0_q) ? (f1_q - f0_q) : '0;
                    end
                    default: begin
                        err_d[1]  = 1'b1;
                        calc_drop = 1'b1;
                    end
                endcase
                if (calc_size == '0) begin
                    calc_drop = 1'b1;
                end
                if (calc_drop) begin
                    state_d = S_IDLE;
                end else begin
                    start_d     = f0_q;
                    remaining_d = calc_size;
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (cfg_valid_q && cfg_ready && cfg_q.last) begin
                    cfg_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (!cfg_valid_q || cfg_ready) begin
                    start_d           = emit_start;
                    remaining_d       = emit_rem;
                    cfg_d.index_start = emit_start;
                    cfg_d.index_end   = emit_start + emit_chunk;
                    cfg_d.array_size  = emit_chunk;
                    cfg_d.meta        = meta_q;
                    cfg_d.last        = (emit_rem == emit_chunk);
                    cfg_valid_d       = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            setup_q     <= 1'b1;
            state_q     <= S_IDLE;
            mode_q      <= '0;
            f0_q        <= '0;
            f1_q        <= '0;
            meta_q      <= '0;
            start_q     <= '0;
            remaining_q <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            setup_q     <= setup_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
            meta_q      <= meta_d;
            start_q     <= start_d;
            remaining_q <= remaining_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            err_q       <= err_d;
        end
    end

    assign cfg_valid         = cfg_valid_q;
    assign cfg_index_start   = cfg_q.index_start;
    assign cfg_index_end     = cfg_q.index_end;
    assign cfg_array_size    = cfg_q.array_size;
    assign cfg_stride        = INDEX_W'(STRIDE);
    assign cfg_meta          = cfg_q.meta;
    assign cfg_last          = cfg_q.last;
    assign err               = err_q;
    assign fifo_setup_signal = setup_q;

`ifdef ENGINE_CSR_INDEX_CHUNK_STATS_EN
    logic [31:0] stat_cfg_q, stat_cfg_d;
    logic [31:0] stat_drop_q, stat_drop_d;
    logic        filt_drop;

    // A filtered input and a CALC-stage drop can land in the same cycle.
    assign filt_drop = in_valid & in_ready & ~id_match;

    always_comb begin
        stat_cfg_d  = stat_cfg_q + 32'(cfg_valid_q & cfg_ready);
        stat_drop_d = stat_drop_q + 32'(filt_drop) + 32'(calc_drop);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            stat_cfg_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_cfg_q  <= stat_cfg_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_cfg_count  = stat_cfg_q;
    assign stat_drop_count = stat_drop_q;
`endif

endmodule

// File: tb/tb_engine_csr_index_chunk_configure_engine.sv
// Directed, table-driven bench for the CSR index chunk configure engine (default build, MAX_CHUNK=256).
module tb_engine_csr_index_chunk_configure_engine;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_buffer = '0;
    logic [1:0]  in_mode = '0;
    logic [31:0] in_field0 = '0;
    logic [31:0] in_field1 = '0;
    logic [63:0] in_meta = '0;
    logic        cfg_valid;
    logic        cfg_ready = 1'b1;
    logic [31:0] cfg_index_start;
    logic [31:0] cfg_index_end;
    logic [31:0] cfg_array_size;
    logic [31:0] cfg_stride;
    logic [63:0] cfg_meta;
    logic        cfg_last;
    logic [1:0]  err;
    logic        fifo_setup_signal;

    always #5 ap_clk = ~ap_clk;

    engine_csr_index_chunk_configure_engine #(
        .MAX_CHUNK (256)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_buffer         (in_buffer),
        .in_mode           (in_mode),
        .in_field0         (in_field0),
        .in_field1         (in_field1),
        .in_meta           (in_meta),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_index_start   (cfg_index_start),
        .cfg_index_end     (cfg_index_end),
        .cfg_array_size    (cfg_array_size),
        .cfg_stride        (cfg_stride),
        .cfg_meta          (cfg_meta),
        .cfg_last          (cfg_last),
        .err               (err),
        .fifo_setup_signal (fifo_setup_signal)
    );

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] z;
        logic        l;
    } chunk_t;

    typedef struct packed {
        logic [3:0]       bid;
        logic [1:0]       mode;
        logic [31:0]      f0;
        logic [31:0]      f1;
        logic [1:0]       n;
        logic [1:0]       err;
        chunk_t [2:0]     exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] z;
        logic [63:0] meta;
        logic        l;
        int          cyc;
    } obs_t;

    localparam int NV = 11;
    vec_t  vecs [NV];
    obs_t  obs_q [$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    acc_cnt = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(negedge ap_clk) begin
        if (cfg_valid && cfg_ready) begin
            obs_q.push_back('{cfg_index_start, cfg_index_end, cfg_array_size, cfg_meta, cfg_last, cyc});
        end
    end

    function automatic chunk_t ck(input logic [31:0] s, input logic [31:0] e, input logic [31:0] z, input logic l);
        ck.s = s; ck.e = e; ck.z = z; ck.l = l;
    endfunction

    function automatic vec_t mkv(input logic [3:0] bid, input logic [1:0] mode, input logic [31:0] f0,
                                 input logic [31:0] f1, input logic [1:0] n, input logic [1:0] e,
                                 input chunk_t c0, input chunk_t c1, input chunk_t c2);
        mkv.bid = bid; mkv.mode = mode; mkv.f0 = f0; mkv.f1 = f1; mkv.n = n; mkv.err = e;
        mkv.exp[0] = c0; mkv.exp[1] = c1; mkv.exp[2] = c2;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] bid, input logic [1:0] mode, input logic [31:0] f0,
                        input logic [31:0] f1, input logic [63:0] meta);
        int k;
        in_valid = 1'b1; in_buffer = bid; in_mode = mode;
        in_field0 = f0; in_field1 = f1; in_meta = meta;
        k = 0;
        while (!in_ready && k < 400) begin
            @(posedge ap_clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
        end else begin
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge ap_clk); #1;
            k++;
        end
        if (obs_q.size() < n) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: got %0d configs, required %0d", name, obs_q.size(), n);
        end
    endtask

    task automatic cmp_obs(input string tag, input int idx, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] z, input logic l, input logic [63:0] meta);
        if (idx >= obs_q.size()) begin
            n_checks++; n_errors++;
            $display("FAIL %s_missing: config %0d absent, only %0d seen", tag, idx, obs_q.size());
        end else begin
            check({tag, "_start"}, 64'(obs_q[idx].s), 64'(s));
            check({tag, "_end"},   64'(obs_q[idx].e), 64'(e));
            check({tag, "_size"},  64'(obs_q[idx].z), 64'(z));
            check({tag, "_last"},  64'(obs_q[idx].l), 64'(l));
            check({tag, "_meta"},  obs_q[idx].meta, meta);
        end
    endtask

    initial begin
        logic [31:0] snap_s, snap_e, snap_z;
        logic        snap_l;
        logic        stable;
        int          hold;
        int          lat;

        vecs[0]  = mkv(4'd1, 2'd0, 32'd100, 32'd600, 2'd3, 2'b00,
                       ck(32'd100, 32'd356, 32'd256, 1'b0), ck(32'd356, 32'd612, 32'd256, 1'b0),
                       ck(32'd612, 32'd700, 32'd88, 1'b1));
        vecs[1]  = mkv(4'd1, 2'd1, 32'd50, 32'd50, 2'd0, 2'b00, '0, '0, '0);
        vecs[2]  = mkv(4'd2, 2'd1, 32'd60, 32'd40, 2'd0, 2'b00, '0, '0, '0);
        vecs[3]  = mkv(4'd7, 2'd0, 32'd0, 32'd10, 2'd0, 2'b00, '0, '0, '0);
        vecs[4]  = mkv(4'd2, 2'd0, 32'd0, 32'd10, 2'd1, 2'b00, ck(32'd0, 32'd10, 32'd10, 1'b1), '0, '0);
        vecs[5]  = mkv(4'd1, 2'd1, 32'd1000, 32'd1256, 2'd1, 2'b00,
                       ck(32'd1000, 32'd1256, 32'd256, 1'b1), '0, '0);
        vecs[6]  = mkv(4'd2, 2'd1, 32'd0, 32'd257, 2'd2, 2'b00,
                       ck(32'd0, 32'd256, 32'd256, 1'b0), ck(32'd256, 32'd257, 32'd1, 1'b1), '0);
        vecs[7]  = mkv(4'd0, 2'd0, 32'd5, 32'd5, 2'd0, 2'b00, '0, '0, '0);
        vecs[8]  = mkv(4'd1, 2'd0, 32'hFFFF_FFF0, 32'h20, 2'd1, 2'b01,
                       ck(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hF, 1'b1), '0, '0);
        vecs[9]  = mkv(4'd1, 2'd2, 32'd1, 32'd5, 2'd0, 2'b11, '0, '0, '0);
        vecs[10] = mkv(4'd2, 2'd0, 32'hFFFF_FF00, 32'hFF, 2'd1, 2'b11,
                       ck(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFF, 1'b1), '0, '0);

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_setup", 64'(fifo_setup_signal), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cfg_last", 64'(cfg_last), 64'd0);
        check("rst_cfg_start", 64'(cfg_index_start), 64'd0);
        check("rst_cfg_size", 64'(cfg_array_size), 64'd0);
        check("stride", 64'(cfg_stride), 64'd1);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("setup_fall", 64'(fifo_setup_signal), 64'd0);
        check("in_ready_up", 64'(in_ready), 64'd1);

        // First-config latency from the accepting edge
        send(4'd1, 2'd0, 32'd8, 32'd4, 64'h1111);
        lat = 0;
        while (!cfg_valid && lat < 12) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        wait_n(1, 10, "lat");
        cmp_obs("lat", 0, 32'd8, 32'd12, 32'd4, 1'b1, 64'h1111);

        for (int i = 0; i < NV; i++) begin
            obs_q.delete();
            send(vecs[i].bid, vecs[i].mode, vecs[i].f0, vecs[i].f1, {32'hA5A5_0000, 32'(i)});
            if (vecs[i].n == 2'd0) begin
                repeat (8) @(posedge ap_clk);
                #1;
            end else begin
                wait_n(int'(vecs[i].n), 30, $sformatf("v%0d", i));
                repeat (4) @(posedge ap_clk);
                #1;
            end
            check($sformatf("v%0d_count", i), 64'(obs_q.size()), 64'(vecs[i].n));
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                cmp_obs($sformatf("v%0d_c%0d", i, k), k, vecs[i].exp[k].s, vecs[i].exp[k].e,
                        vecs[i].exp[k].z, vecs[i].exp[k].l, {32'hA5A5_0000, 32'(i)});
            end
            if (i == 0 && obs_q.size() == 3) begin
                check("v0_b2b_1", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd1);
                check("v0_b2b_2", 64'(obs_q[2].cyc - obs_q[1].cyc), 64'd1);
            end
            check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].err));
        end

        // Stall mid-split while flooding the input FIFO
        obs_q.delete();
        cfg_ready = 1'b1;
        send(4'd1, 2'd0, 32'd0, 32'd600, 64'hBEEF);
        wait_n(1, 20, "bp_first");
        cfg_ready = 1'b0;
        snap_s = cfg_index_start; snap_e = cfg_index_end; snap_z = cfg_array_size; snap_l = cfg_last;
        check("bp_stall_start", 64'(snap_s), 64'd256);
        acc_cnt = 0;
        fork
            begin
                for (int j = 0; j < 20; j++) begin
                    send((j % 2 == 1) ? 4'd2 : 4'd1, 2'd1, 32'(j * 10), 32'(j * 10 + j + 1), 64'(j));
                    acc_cnt++;
                end
            end
            begin
                stable = 1'b1;
                hold = 0;
                while ((hold < 10 || acc_cnt < 16) && hold < 300) begin
                    @(posedge ap_clk); #2;
                    hold++;
                    if (!cfg_valid || cfg_index_start !== snap_s || cfg_index_end !== snap_e ||
                        cfg_array_size !== snap_z || cfg_last !== snap_l) begin
                        stable = 1'b0;
                    end
                end
                check("bp_stable", 64'(stable), 64'd1);
                check("bp_accepted", 64'(acc_cnt), 64'd16);
                check("bp_in_ready_full", 64'(in_ready), 64'd0);
                cfg_ready = 1'b1;
            end
        join
        wait_n(23, 600, "bp_drain");
        repeat (4) @(posedge ap_clk);
        #1;
        check("bp_count", 64'(obs_q.size()), 64'd23);
        cmp_obs("bp_c1", 1, 32'd256, 32'd512, 32'd256, 1'b0, 64'hBEEF);
        cmp_obs("bp_c2", 2, 32'd512, 32'd600, 32'd88, 1'b1, 64'hBEEF);
        for (int j = 0; j < 20; j++) begin
            cmp_obs($sformatf("bp_p%0d", j), 3 + j, 32'(j * 10), 32'(j * 10 + j + 1), 32'(j + 1), 1'b1, 64'(j));
        end

        // Reset while the second chunk is presented, with two packets still buffered
        obs_q.delete();
        cfg_ready = 1'b0;
        send(4'd1, 2'd0, 32'd0, 32'd600, 64'hCAFE);
        send(4'd2, 2'd0, 32'd5, 32'd5, 64'hD00D);
        send(4'd1, 2'd1, 32'd3, 32'd9, 64'hF00D);
        lat = 0;
        while (!cfg_valid && lat < 20) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        check("mr_valid", 64'(cfg_valid), 64'd1);
        cfg_ready = 1'b1;
        @(posedge ap_clk); #1;
        cfg_ready = 1'b0;
        check("mr_second_chunk", 64'(cfg_index_start), 64'd256);
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        check("mr_cfg_valid", 64'(cfg_valid), 64'd0);
        check("mr_err", 64'(err), 64'd0);
        check("mr_setup", 64'(fifo_setup_signal), 64'd1);
        check("mr_in_ready", 64'(in_ready), 64'd0);
        check("mr_cfg_last", 64'(cfg_last), 64'd0);
        check("mr_cfg_start", 64'(cfg_index_start), 64'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        check("mr_setup_fall", 64'(fifo_setup_signal), 64'd0);
        cfg_ready = 1'b1;
        repeat (8) @(posedge ap_clk);
        #1;
        check("mr_flushed", 64'(obs_q.size()), 64'd1);
        obs_q.delete();
        send(4'd2, 2'd1, 32'd20, 32'd30, 64'h5150);
        wait_n(1, 20, "mr_new");
        repeat (3) @(posedge ap_clk);
        #1;
        check("mr_new_count", 64'(obs_q.size()), 64'd1);
        cmp_obs("mr_new", 0, 32'd20, 32'd30, 32'd10, 1'b1, 64'h5150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
